// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the load/store unit: RV32I load/store funct3
// encodings, the datapath width and the LSU state encoding.
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    // RV32I load/store width encodings (funct3 field)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
//   funct3, offset (addr[1:0]), store  -> byte enables, misaligned flag
//   wdata                              -> store data replicated into lanes
//   rdata                              -> load result shifted down and
//                                         sign/zero-extended
// Ports:
//   store       in   1 = store, 0 = load
//   funct3      in   RV32I width encoding
//   offset      in   byte offset within the word
//   wdata       in   raw store data (rs2)
//   rdata       in   raw word from data memory
//   be          out  byte enables
//   lane_wdata  out  store data placed on the correct lanes
//   rdata_ext   out  extracted, extended load data
//   misaligned  out  access misaligned or funct3 undefined
// -----------------------------------------------------------------------------
module lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            store,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] lane_wdata,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned
);

    logic [XLEN-1:0] shifted;

    // Bring the addressed byte/halfword down to bit 0.
    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        be         = 4'b0000;
        lane_wdata = wdata;
        rdata_ext  = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be         = 4'b0001 << offset;
                lane_wdata = {4{wdata[7:0]}};
                rdata_ext  = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                              : {24'd0, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                be         = 4'b0011 << offset;
                lane_wdata = {2{wdata[15:0]}};
                rdata_ext  = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                              : {16'd0, shifted[15:0]};
                misaligned = offset[0];
            end
            F3_W: begin
                be         = 4'b1111;
                rdata_ext  = shifted;
                misaligned = (offset != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
        // Unsigned widths exist only for loads; a store with them is undefined.
        if (store && funct3[2])
            misaligned = 1'b1;
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory stage: takes the ALU result as effective address and rs2 as store
// data, issues one outstanding data-memory request at a time and returns the
// aligned/extended load result. Misaligned or undefined accesses complete as a
// one-cycle fault without touching memory.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   in_valid/in_ready  op handshake from EX (ready only in IDLE)
//   in_store, in_funct3, in_addr, in_wdata   op description
//   mem_req/mem_gnt    request handshake to data memory
//   mem_we, mem_addr, mem_be, mem_wdata      request payload (word address)
//   mem_rvalid, mem_rdata                    memory response
//   out_valid          one-cycle completion pulse
//   out_rdata          load result (0 for stores and faults)
//   out_misaligned     completion is a misaligned-access fault
// -----------------------------------------------------------------------------
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_store,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_rdata,
    output logic            out_misaligned
);

    lsu_state_t  state;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;

    logic        al_store;
    logic [2:0]  al_funct3;
    logic [1:0]  al_offset;
    logic [3:0]  al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;
    logic        al_misaligned;

    // Out_valid does not gate acceptance: a new op may enter on the completion cycle.
    assign in_ready = (state == IDLE);

    // The aligner is shared: in IDLE it decodes the incoming op, afterwards it
    // works from the captured op to extract the load response.
    assign al_store  = (state == IDLE) ? in_store     : store_q;
    assign al_funct3 = (state == IDLE) ? in_funct3    : funct3_q;
    assign al_offset = (state == IDLE) ? in_addr[1:0] : offset_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .store      (al_store),
        .funct3     (al_funct3),
        .offset     (al_offset),
        .wdata      (in_wdata),
        .rdata      (mem_rdata),
        .be         (al_be),
        .lane_wdata (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_misaligned)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            store_q        <= 1'b0;
            funct3_q       <= 3'b000;
            offset_q       <= 2'b00;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= 4'b0000;
            mem_wdata      <= '0;
            out_valid      <= 1'b0;
            out_rdata      <= '0;
            out_misaligned <= 1'b0;
        end else begin
            out_valid      <= 1'b0;
            out_misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        store_q  <= in_store;
                        funct3_q <= in_funct3;
                        offset_q <= in_addr[1:0];
                        if (al_misaligned) begin
                            state          <= FAULT;
                            out_valid      <= 1'b1;
                            out_misaligned <= 1'b1;
                            out_rdata      <= '0;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= in_store;
                            mem_addr  <= {in_addr[XLEN-1:2], 2'b00};
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                        end
                    end
                end
                REQ: begin
                    // Payload registers stay untouched until the grant.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        out_rdata <= store_q ? '0 : al_rdata;
                    end
                end
                FAULT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point, well clear of the edge.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_rdata;
    logic        out_misaligned;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_store       (in_store),
        .in_funct3      (in_funct3),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .mem_req        (mem_req),
        .mem_gnt        (mem_gnt),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_rdata      (out_rdata),
        .out_misaligned (out_misaligned)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accepting cycle.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        in_store  = st;
        in_funct3 = f3;
        in_addr   = addr;
        in_wdata  = wd;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    // Drive the memory side of an issued, aligned op and check the request and
    // the completion. gnt_delay cycles of REQ pass before mem_gnt is raised.
    task automatic complete(input string tag, input int gnt_delay, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic exp_we, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rdata);
        for (int i = 0; i <= gnt_delay; i++) begin
            check({tag, " mem_req"}, {31'd0, mem_req}, 32'd1);
            check({tag, " mem_addr"}, mem_addr, exp_addr);
            check({tag, " mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
            check({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
        end
        check({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, exp_we});
        if (exp_we)
            check({tag, " mem_wdata"}, mem_wdata, exp_wdata);
        for (int i = 0; i < gnt_delay; i++) begin
            tick();
            check({tag, " mem_req held"}, {31'd0, mem_req}, 32'd1);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check({tag, " req dropped in WAIT"}, {31'd0, mem_req}, 32'd0);
        check({tag, " no early out_valid"}, {31'd0, out_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, " out_rdata"}, out_rdata, exp_rdata);
        check({tag, " out_misaligned"}, {31'd0, out_misaligned}, 32'd0);
        check({tag, " in_ready done"}, {31'd0, in_ready}, 32'd1);
        tick();
        check({tag, " out_valid pulse"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_store   = 1'b0;
        in_funct3  = 3'b000;
        in_addr    = '0;
        in_wdata   = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        tick();
        tick();

        // Reset state
        check("rst mem_req", {31'd0, mem_req}, 32'd0);
        check("rst mem_we", {31'd0, mem_we}, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_be", {28'd0, mem_be}, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_rdata", out_rdata, 32'd0);
        check("rst out_misaligned", {31'd0, out_misaligned}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        tick();

        // LW 0x100, immediate grant
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        complete("lw", 0, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF);

        // LB / LBU 0x103 on the top lane
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        complete("lb", 0, 32'h80FF_0000, 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 32'hFFFF_FF80);
        issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
        complete("lbu", 0, 32'h80FF_0000, 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 32'h0000_0080);

        // LHU 0x102 zero-extends the upper halfword
        issue(1'b0, 3'b101, 32'h0000_0102, 32'h0);
        complete("lhu", 1, 32'h9ABC_0000, 32'h0000_0100, 4'b1100, 1'b0, 32'h0, 32'h0000_9ABC);

        // SH 0x202, grant 3 cycles late: request visible for 4 cycles
        issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
        complete("sh", 3, 32'h5555_5555, 32'h0000_0200, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'h0);

        // SB 0x301 replicates the low byte
        issue(1'b1, 3'b000, 32'h0000_0301, 32'hCAFE_F00D);
        complete("sb", 0, 32'h0, 32'h0000_0300, 4'b0010, 1'b1, 32'h0D0D_0D0D, 32'h0);

        // Misaligned LW 0x101: fault completion, no request
        issue(1'b0, 3'b010, 32'h0000_0101, 32'h0);
        check("mis mem_req", {31'd0, mem_req}, 32'd0);
        check("mis out_valid", {31'd0, out_valid}, 32'd1);
        check("mis out_misaligned", {31'd0, out_misaligned}, 32'd1);
        check("mis out_rdata", out_rdata, 32'd0);
        check("mis in_ready in fault", {31'd0, in_ready}, 32'd0);
        tick();
        check("mis in_ready after", {31'd0, in_ready}, 32'd1);
        check("mis out_valid pulse", {31'd0, out_valid}, 32'd0);
        check("mis out_misaligned clr", {31'd0, out_misaligned}, 32'd0);

        // Undefined funct3 and misaligned halfword also fault
        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0);
        check("f3 undef misaligned", {31'd0, out_misaligned}, 32'd1);
        check("f3 undef mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        issue(1'b0, 3'b001, 32'h0000_0103, 32'h0);
        check("lh odd misaligned", {31'd0, out_misaligned}, 32'd1);
        tick();

        // Reset while waiting for the response
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("rstw in WAIT req low", {31'd0, mem_req}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstw in_ready", {31'd0, in_ready}, 32'd1);
        check("rstw mem_addr", mem_addr, 32'd0);
        check("rstw mem_be", {28'd0, mem_be}, 32'd0);
        check("rstw out_valid", {31'd0, out_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        tick();
        mem_rvalid = 1'b0;
        check("rstw late rvalid ignored", {31'd0, out_valid}, 32'd0);
        check("rstw late rvalid rdata", out_rdata, 32'd0);

        // Back-to-back: second op held on in_valid while the first is in flight
        in_store  = 1'b0;
        in_funct3 = 3'b001;
        in_addr   = 32'h0000_0102;
        in_valid  = 1'b1;
        tick();
        in_funct3 = 3'b010;
        in_addr   = 32'h0000_0204;
        check("b2b busy in_ready", {31'd0, in_ready}, 32'd0);
        check("b2b first addr", mem_addr, 32'h0000_0100);
        check("b2b first be", {28'd0, mem_be}, 32'h0000_000C);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("b2b wait in_ready", {31'd0, in_ready}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8001_0000;
        tick();
        mem_rvalid = 1'b0;
        check("b2b first out_valid", {31'd0, out_valid}, 32'd1);
        check("b2b first rdata", out_rdata, 32'hFFFF_8001);
        check("b2b ready on completion", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        complete("b2b second", 0, 32'h1122_3344, 32'h0000_0204, 4'b1111, 1'b0, 32'h0, 32'h1122_3344);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
